// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default operand width for the serial subtractor.
package serial_sub_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/fs_bit_cell.sv
// fs_bit_cell: combinational 1-bit full subtractor, d = x - y - bi with borrow-out bo.
module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & (y | bi)) | (y & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin, LSB first, one bit per clock through a single cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, bo;
    logic [WIDTH:0]   dsh;
    fs_bit_cell u_cell (.x(sa[0]), .y(sb[0]), .bi(br), .d(d), .bo(bo));
    // new difference bit enters at the MSB; the oldest bit ends up at the LSB after WIDTH shifts
    assign dsh = {d, diff};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                    sa    <= a;
                    sb    <= b;
                    br    <= bin;
                    cnt   <= '0;
                end
                SHIFT: begin
                    diff <= dsh[WIDTH:1];
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= bo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        // overflow when the borrow into the sign bit differs from the borrow out of it
                        ovf   <= br ^ bo;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed bench with an arithmetic reference model and per-cycle compare.
module tb_serial_sub_ctrl;
    localparam int W = 8;
    logic clk = 0, rst = 1, start = 0, bin = 0;
    logic [W-1:0] a = 0, b = 0;
    logic busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
`endif
    int tests = 0, fails = 0;
    int cyc = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .bout(bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: plain integer arithmetic, result = {ovf, bout, diff}
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int full, sx, sy, s;
        logic [31:0] fv;
        full = int'(x) - int'(y) - int'(c);
        sx = int'(x) - (x[W-1] ? (1 << W) : 0);
        sy = int'(y) - (y[W-1] ? (1 << W) : 0);
        s = sx - sy - int'(c);
        fv = full;
        return {(s < -(1 << (W - 1))) || (s >= (1 << (W - 1))), full < 0, fv[W-1:0]};
    endfunction

    // model: rem counts cycles left in an operation; done expected when rem==1
    int rem = 0;
    logic [W+1:0] pend = '0, res = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= 0;
            res <= '0;
        end else if (rem == 0) begin
            if (start) begin
                rem  <= W + 1;
                pend <= ref_sub(a, b, bin);
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) res <= pend;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(rem != 0));
            check("done", 32'(done), 32'(rem == 1));
            if (rem <= 1) begin
                check("diff", 32'(diff), 32'(res[W-1:0]));
                check("bout", 32'(bout), 32'(res[W]));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(res[W+1]));
`endif
            end
        end
    end

    task automatic wait_done(inout int n);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    // caller is at a negedge; start is sampled at the next edge (cycle 0 ends there)
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        a = x; b = y; bin = c; start = 1;
        @(negedge clk);
        start = 0;
        n = 1;
        wait_done(n);
        check({name, "_lat"}, 32'(n), 32'(W + 1));
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) check({name, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
        @(negedge clk);
        check({name, "_idle"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int n, t0;
        int dc[3];
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dc[3];
        logic [W-1:0] bx[3] = '{8'h01, 8'hA0, 8'h3C};
        logic [W-1:0] by[3] = '{8'h02, 8'h20, 8'h3C};
        logic         bc[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] bd[3] = '{8'hFF, 8'h7F, 8'h00};
        logic         bb[3] = '{1'b1, 1'b0, 1'b0};
        @(negedge clk);
        check("rst_out", 32'({busy, done, bout, diff}), 32'd0);
        @(negedge clk);
        rst = 0;
        run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op("neg1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("binb", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("ovfp", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("small", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("ovfn", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        // start with new operands in cycle 4 must be ignored
        a = 8'h33; b = 8'h11; bin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1; start = 1;
        @(negedge clk);
        start = 0;
        n = 5;
        wait_done(n);
        check("ign_lat", 32'(n), 32'd9);
        check("ign_diff", 32'(diff), 32'h22);
        check("ign_bout", 32'(bout), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("ign_no_done", 32'({busy, done}), 32'd0);
        end
        // reset in cycle 5 discards the operation
        a = 8'hC8; b = 8'h64; bin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        check("mid_rst", 32'({busy, done, bout, diff}), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        check("rst_hold", 32'({busy, done, bout, diff}), 32'd0);
        rst = 0;
        run_op("post_rst", 8'h64, 8'hC8, 1'b1, 8'h9B, 1'b1, 1'b1);
        // start held high: one accept every W+2 cycles
        a = bx[0]; b = by[0]; bin = bc[0]; start = 1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(n);
            dc[i] = cyc;
            check("b2b_diff", 32'(diff), 32'(bd[i]));
            check("b2b_bout", 32'(bout), 32'(bb[i]));
            if (i < 2) begin
                a = bx[i+1]; b = by[i+1]; bin = bc[i+1];
            end else start = 0;
            @(negedge clk);
            n = 0;
        end
        check("b2b_first", 32'(dc[0] >= 0), 32'd1);
        check("b2b_period1", 32'(dc[1] - dc[0]), 32'(W + 2));
        check("b2b_period2", 32'(dc[2] - dc[1]), 32'(W + 2));
        repeat (12) @(negedge clk);
        check("end_idle", 32'({busy, done}), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; sampled with an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; sampled with an accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in; sampled with an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: final borrow-out, 1 iff a < b + bin (unsigned).

Function
REQ-012 The block SHALL compute the subtraction bit-serially, LSB first, through one 1-bit difference/borrow cell, one bit per clock.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 The FSM SHALL move from IDLE to SHIFT on an edge with start=1, latching a and b into shift registers, bin into the borrow register, and clearing the bit counter.
REQ-015 In SHIFT, each edge SHALL shift the cell difference into diff at the MSB end, shift a and b right by one, load the cell borrow into the borrow register, and increment the counter.
REQ-016 The FSM SHALL move from SHIFT to DONE on the edge where the counter equals WIDTH-1; the counter is $clog2(WIDTH)+1 bits and never wraps.
REQ-017 The FSM SHALL assert done for exactly one cycle in DONE and return to IDLE on the next edge.
REQ-018 With a start edge at cycle 0, done SHALL be high in cycle WIDTH+1, giving a latency of WIDTH+1 cycles.
REQ-019 The block SHALL ignore start in SHIFT and DONE (no queuing); an input change while busy SHALL NOT affect the result.
REQ-020 The block SHALL hold diff and bout stable from DONE until the next accepted start.
REQ-021 The block SHALL update bout at the same edge as the final diff bit.
REQ-022 WIDTH=1 SHALL be legal: a single SHIFT cycle, with done in cycle 2.

Reset
REQ-023 Asserting rst SHALL force state to IDLE and clear busy, done, diff, bout, the counter, the shift registers and the borrow register, including mid-SHIFT; an operation in progress is discarded.
REQ-024 The first start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN SHALL be the configuration feature; when defined, it adds output ovf (1 bit), the signed two's-complement overflow of a - b - bin, updated and held with bout and reset to 0.
REQ-026 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 Sub-module fs_bit_cell SHALL be the combinational 1-bit cell (inputs x, y, bi; outputs d, bo), instantiated once.
REQ-029 The top level SHALL contain only the FSM, counter, shift registers and borrow register.

Verification (WIDTH=8)
REQ-030 Bench SHALL check: a=0x5A, b=0x3C, bin=0, start at cycle 0 -> diff=0x1E, bout=0, done only in cycle 9, busy in cycles 1-9.
REQ-031 Bench SHALL check: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; and a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
REQ-032 Bench SHALL check: start pulsed with new operands in cycle 4 of an operation -> ignored; the first result is unchanged and no second done appears.
REQ-033 Bench SHALL check: rst asserted in cycle 5 of an operation -> all outputs 0 immediately, state IDLE; a fresh start then completes correctly.
REQ-034 Bench SHALL check, with SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0; and a=0x05, b=0x03 -> ovf=0.
REQ-035 Bench SHALL check: back-to-back start held high -> a new operation is accepted every WIDTH+2 cycles, each with correct results.
